pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile.sv | 114 +++++++++++
 tb/tb_pipe_regfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile.sv
// Pipelined register file with registered read ports, optional write bypass,
// and a per-register busy scoreboard for in-flight destination claims.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_en[NRD]               per-port read enable
//   rd_addr[NRD*AW]          packed read addresses (port i at [i*AW +: AW])
//   rd_data[NRD*XLEN]        packed registered read data
//   rd_busy[NRD]             registered busy flag of the address read
//   we, waddr, wdata         write port (also clears busy[waddr])
//   claim, claim_addr        scoreboard claim (sets busy[claim_addr])
//   busy_cnt[AW+1]           registered number of busy registers
//   dbg_addr, dbg_data       combinational debug read, no bypass
module pipe_regfile #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                claim,
    input  logic [AW-1:0]       claim_addr,
    output logic [AW:0]         busy_cnt,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wr_ok;
    logic             cl_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);
    assign cl_ok = claim && !(ZERO_REG != 0 && claim_addr == '0);

    // Clear first, then set: a new producer claiming the register being
    // written in the same cycle keeps it busy.
    always_comb begin
        busy_next = busy;
        if (wr_ok) busy_next[waddr] = 1'b0;
        if (cl_ok) busy_next[claim_addr] = 1'b1;
    end

    // Count tracks actual bit transitions, so re-claims and writes to idle
    // registers leave it unchanged.
    assign cnt_inc = cl_ok && !busy[claim_addr];
    assign cnt_dec = wr_ok && busy[waddr] && !(cl_ok && claim_addr == waddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) regs[waddr] <= wdata;
            busy <= busy_next;
            if (cnt_inc && !cnt_dec) busy_cnt <= busy_cnt + 1'b1;
            else if (!cnt_inc && cnt_dec) busy_cnt <= busy_cnt - 1'b1;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_n;
        logic            busy_n;
        logic [XLEN-1:0] data_q;
        logic            busy_q;
        logic            zero_hit;
        logic            fwd_hit;

        assign addr     = rd_addr[g*AW +: AW];
        assign zero_hit = ZERO_REG != 0 && addr == '0;
        assign fwd_hit  = BYPASS != 0 && wr_ok && waddr == addr;

        always_comb begin
            data_n = regs[addr];
            busy_n = (BYPASS != 0) ? busy_next[addr] : busy[addr];
            if (fwd_hit) data_n = wdata;
            if (zero_hit) begin
                data_n = '0;
                busy_n = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (rd_en[g]) begin
                data_q <= data_n;
                busy_q <= busy_n;
            end
        end

        assign rd_data[g*XLEN +: XLEN] = data_q;
        assign rd_busy[g]              = busy_q;
    end

    assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: a BYPASS=1 and a BYPASS=0 instance
// share stimulus; a reference model feeds an expected-result queue.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        claim;
    logic [4:0]  claim_addr;
    logic [4:0]  dbg_addr;

    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;
    logic [31:0] dbg_data, dbg_data_nb;

    pipe_regfile #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .we(we), .waddr(waddr),
        .wdata(wdata), .claim(claim), .claim_addr(claim_addr),
        .busy_cnt(busy_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    pipe_regfile #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .we(we), .waddr(waddr),
        .wdata(wdata), .claim(claim), .claim_addr(claim_addr),
        .busy_cnt(busy_cnt_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        bit          nb;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        q[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] m_rd  [2];
    logic [31:0] m_rdn [2];
    logic        m_rb  [2];
    logic        m_rbn [2];

    task automatic idle();
        rd_en = '0; rd_addr = '0; we = 0; waddr = '0; wdata = '0;
        claim = 0; claim_addr = '0; dbg_addr = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        m_busy = '0;
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = '0; m_rdn[p] = '0; m_rb[p] = 0; m_rbn[p] = 0;
        end
    endtask

    // Push expectations for the current inputs, advance one edge, compare.
    task automatic step();
        logic [31:0] nbz;
        logic [31:0] exp_dbg;
        logic [31:0] act_d;
        logic        act_b;
        logic [4:0]  a;
        bit          wok, cok;
        exp_t        e;
        wok = we && waddr != 0;
        cok = claim && claim_addr != 0;
        nbz = m_busy;
        if (wok) nbz[waddr] = 1'b0;
        if (cok) nbz[claim_addr] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*5 +: 5];
                if (a == 0) begin
                    m_rd[p] = '0; m_rb[p] = 0; m_rdn[p] = '0; m_rbn[p] = 0;
                end else begin
                    m_rd[p]  = (wok && waddr == a) ? wdata : m_regs[a];
                    m_rb[p]  = nbz[a];
                    m_rdn[p] = m_regs[a];
                    m_rbn[p] = m_busy[a];
                end
            end
            q.push_back('{p, 1'b0, m_rd[p], m_rb[p]});
            q.push_back('{p, 1'b1, m_rdn[p], m_rbn[p]});
        end
        if (wok) m_regs[waddr] = wdata;
        m_busy = nbz;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            act_d = e.nb ? rd_data_nb[e.port*32 +: 32] : rd_data[e.port*32 +: 32];
            act_b = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
            vecs++;
            if (act_d !== e.data || act_b !== e.busy) begin
                errs++;
                $display("FAIL rd port%0d nb=%0d: got %h/%b want %h/%b",
                         e.port, e.nb, act_d, act_b, e.data, e.busy);
            end
        end
        vecs++;
        if (busy_cnt !== 6'($countones(m_busy)) || busy_cnt_nb !== busy_cnt) begin
            errs++;
            $display("FAIL busy_cnt: got %0d/%0d want %0d",
                     busy_cnt, busy_cnt_nb, $countones(m_busy));
        end
        exp_dbg = (dbg_addr == 0) ? '0 : m_regs[dbg_addr];
        vecs++;
        if (dbg_data !== exp_dbg || dbg_data_nb !== exp_dbg) begin
            errs++;
            $display("FAIL dbg r%0d: got %h/%h want %h",
                     dbg_addr, dbg_data, dbg_data_nb, exp_dbg);
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        model_reset();
        #1;
        vecs++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_cnt !== '0) begin
            errs++;
            $display("FAIL reset_state: got %h %b %0d want 0", rd_data, rd_busy, busy_cnt);
        end
        we = 1; waddr = 5; wdata = 32'h5555_5555;
        claim = 1; claim_addr = 6; rd_en = 2'b11; rd_addr = {5'd6, 5'd5};
        @(posedge clk);
        #1;
        dbg_addr = 5;
        #1;
        vecs++;
        if (rd_data !== '0 || busy_cnt !== '0 || dbg_data !== '0) begin
            errs++;
            $display("FAIL reset_ignores: got %h %0d %h want 0", rd_data, busy_cnt, dbg_data);
        end
        idle();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            rd_en = 2'b01; rd_addr = {5'd0, 5'(i)}; dbg_addr = 5'(i);
            step();
        end
    endtask

    task automatic test_write_read();
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        step();
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5}; dbg_addr = 5;
        step();
        vecs++;
        if (rd_data !== {2{32'hDEAD_BEEF}}) begin
            errs++;
            $display("FAIL r5_dual: got %h want %h", rd_data, {2{32'hDEAD_BEEF}});
        end
        we = 1; waddr = 0; wdata = 32'h1234;
        step();
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        vecs++;
        if (rd_data !== '0) begin
            errs++;
            $display("FAIL r0_zero: got %h want 0", rd_data);
        end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 7; wdata = 32'h1111_1111;
        step();
        we = 1; waddr = 7; wdata = 32'hA5A5_A5A5;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        step();
        vecs++;
        if (rd_data[31:0] !== 32'hA5A5_A5A5 || rd_data_nb[31:0] !== 32'h1111_1111) begin
            errs++;
            $display("FAIL bypass: got %h/%h want a5a5a5a5/11111111",
                     rd_data[31:0], rd_data_nb[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        claim = 1; claim_addr = 3; step();
        claim = 1; claim_addr = 4; step();
        vecs++;
        if (busy_cnt !== 6'd2) begin
            errs++;
            $display("FAIL claim_two: got %0d want 2", busy_cnt);
        end
        claim = 1; claim_addr = 3; rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        we = 1; waddr = 3; wdata = 32'h33; claim = 1; claim_addr = 4;
        rd_en = 2'b11; rd_addr = {5'd4, 5'd3};
        step();
        vecs++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b10) begin
            errs++;
            $display("FAIL wr_claim: got %0d/%b want 1/10", busy_cnt, rd_busy);
        end
        claim = 1; claim_addr = 9; we = 1; waddr = 9; wdata = 32'h99;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
        step();
        vecs++;
        if (busy_cnt !== 6'd2 || rd_busy[0] !== 1'b1) begin
            errs++;
            $display("FAIL same_addr: got %0d/%b want 2/1", busy_cnt, rd_busy[0]);
        end
        claim = 1; claim_addr = 0; rd_en = 2'b01; rd_addr = '0;
        step();
        vecs++;
        if (busy_cnt !== 6'd2 || rd_busy[0] !== 1'b0) begin
            errs++;
            $display("FAIL claim_r0: got %0d/%b want 2/0", busy_cnt, rd_busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
            claim = 1'($urandom); claim_addr = 5'($urandom);
            rd_en = 2'($urandom); dbg_addr = 5'($urandom);
            rd_addr = (i % 4 == 0) ? {waddr, waddr} : 10'($urandom);
            step();
        end
    endtask

    task automatic test_async_reset();
        claim = 1; claim_addr = 12; rd_en = 2'b11; rd_addr = {5'd12, 5'd5};
        step();
        we = 1; waddr = 5; wdata = 32'hCAFE_F00D; claim = 1; claim_addr = 13;
        #2;
        rst = 1;
        dbg_addr = 5;
        #1;
        vecs++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_cnt !== '0 ||
            dbg_data !== '0 || rd_data_nb !== '0 || busy_cnt_nb !== '0) begin
            errs++;
            $display("FAIL async_reset: got %h %b %0d %h", rd_data, rd_busy, busy_cnt, dbg_data);
        end
        #3;
        idle();
        rst = 0;
        model_reset();
        rd_en = 2'b11; rd_addr = {5'd13, 5'd5}; dbg_addr = 5;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
